// File: rtl/shift_pkg.sv
// Shared types for the shift operand-issue stage: funct codes, shifter ctrl
// encodings, skid-buffer state enum and the issued payload layout.
package shift_pkg;

  localparam int PAY_DATA_W = 32;
  localparam int PAY_RD_W   = 5;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_PASS = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [PAY_DATA_W-1:0] a;
    logic [PAY_DATA_W-1:0] b;
    logic [1:0]            ctrl;
    logic [PAY_RD_W-1:0]   rd;
    logic                  illegal;
  } shift_payload_t;

endpackage

// File: rtl/shift_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is registered so it never
// depends combinationally on out_ready; it stays low while reset is asserted.
module shift_skid_buf
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q;
  logic         in_xfer, out_xfer;
  logic         load_main, load_skid, skid_to_main;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && rdy_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      ST_EMPTY: if (in_xfer) begin
        load_main = 1'b1;
        state_d   = ST_ONE;
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_xfer) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: if (out_xfer) begin
        skid_to_main = 1'b1;
        state_d      = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // rdy_q mirrors (state != FULL) one edge ahead, so it equals the decoded
  // state after every edge but still reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_FULL);
      if (load_main)         main_q <= in_data;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= in_data;
    end
  end

endmodule

// File: rtl/shift_issue.sv
// Shift operand-issue stage: decodes R-type shift funct into shifter A/B/ctrl
// and issues through a skid buffer. Option: SHIFT_ISSUE_R0_SQUASH_EN drops legal rd==0.
module shift_issue
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_illegal
);

  shift_payload_t dec, pay;
  logic           squash, buf_in_valid;

  always_comb begin
    dec         = '0;
    dec.b       = in_rt;
    dec.rd      = in_rd;
    dec.ctrl    = SH_PASS;
    dec.illegal = 1'b1;
    case (in_funct)
      F_SLL:  begin dec.ctrl = SH_SLL; dec.a = {27'b0, in_shamt};  dec.illegal = 1'b0; end
      F_SRL:  begin dec.ctrl = SH_SRL; dec.a = {27'b0, in_shamt};  dec.illegal = 1'b0; end
      F_SRA:  begin dec.ctrl = SH_SRA; dec.a = {27'b0, in_shamt};  dec.illegal = 1'b0; end
      F_SLLV: begin dec.ctrl = SH_SLL; dec.a = {27'b0, in_rs[4:0]}; dec.illegal = 1'b0; end
      F_SRLV: begin dec.ctrl = SH_SRL; dec.a = {27'b0, in_rs[4:0]}; dec.illegal = 1'b0; end
      F_SRAV: begin dec.ctrl = SH_SRA; dec.a = {27'b0, in_rs[4:0]}; dec.illegal = 1'b0; end
      default: ;
    endcase
  end

  // A squashed instruction still handshakes upstream but never enters the buffer.
`ifdef SHIFT_ISSUE_R0_SQUASH_EN
  assign squash = !dec.illegal && (in_rd == '0);
`else
  assign squash = 1'b0;
`endif
  assign buf_in_valid = in_valid && !squash;

  shift_skid_buf #(.W($bits(shift_payload_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (buf_in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay)
  );

  assign out_a       = pay.a;
  assign out_b       = pay.b;
  assign out_ctrl    = pay.ctrl;
  assign out_rd      = pay.rd;
  assign out_illegal = pay.illegal;

endmodule
